// File: rtl/irq_encoder_8to3_pkg.sv
// Shared constants and FSM state type for the 8-to-3 interrupt request encoder.
package irq_encoder_8to3_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/irq_select_8.sv
// Combinational request selector: finds the first set bit of pending when
// searching upward from index start, wrapping 7 -> 0. start = 0 gives
// plain lowest-index priority.
module irq_select_8
  import irq_encoder_8to3_pkg::*;
(
  input  logic [N_REQ-1:0]  pending,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  logic [CODE_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    code = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = start + CODE_W'(k);
      if (pending[idx]) begin
        code = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_encoder_8to3.sv
// Captures up to eight interrupt requests into a pending set and presents
// them one at a time as a 3-bit code over a valid/ready handshake.
// EDGE = 1 captures rising edges of req_in, EDGE = 0 captures levels.
// Define IRQ_ENC_ROUND_ROBIN_EN for round-robin selection starting after the
// last transferred index; otherwise the lowest pending index is presented.
module irq_encoder_8to3
  import irq_encoder_8to3_pkg::*;
#(
  parameter int EDGE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_in,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_REQ-1:0]  pending,
  output logic              overflow
);

  state_t            state;
  state_t            state_next;
  logic [N_REQ-1:0]  req_q;
  logic [N_REQ-1:0]  capture;
  logic [N_REQ-1:0]  clear_mask;
  logic [N_REQ-1:0]  pending_kept;
  logic              transfer;
  logic [CODE_W-1:0] sel_start;
  logic [CODE_W-1:0] sel_code;
  logic              sel_any;
  logic [CODE_W-1:0] code_next;

  // New requests this cycle: rising edges against the delayed copy, or raw levels.
  always_comb begin
    if (EDGE != 0) begin
      capture = req_in & ~req_q;
    end else begin
      capture = req_in;
    end
  end

  // The accepted bit is removed first; selection looks only at what survives.
  always_comb begin
    transfer     = out_valid & out_ready;
    clear_mask   = transfer ? (N_REQ'(1) << out_code) : '0;
    pending_kept = pending & ~clear_mask;
  end

`ifdef IRQ_ENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0] rr_ptr;

  // On a transfer edge the pointer is effectively the index being accepted.
  always_comb begin
    sel_start = transfer ? (out_code + CODE_W'(1)) : (rr_ptr + CODE_W'(1));
  end

  // Remember the most recently transferred index as the round-robin origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= CODE_W'(N_REQ - 1);
    end else if (transfer) begin
      rr_ptr <= out_code;
    end
  end
`else
  // Fixed priority always searches from index 0.
  always_comb begin
    sel_start = '0;
  end
`endif

  irq_select_8 u_select (
    .pending (pending_kept),
    .start   (sel_start),
    .code    (sel_code),
    .any     (sel_any)
  );

  // Presentation FSM: load a code when idle, hold under backpressure, reload back-to-back.
  always_comb begin
    state_next = state;
    code_next  = out_code;
    case (state)
      IDLE: begin
        if (sel_any) begin
          state_next = PRESENT;
          code_next  = sel_code;
        end
      end
      PRESENT: begin
        if (transfer) begin
          if (sel_any) begin
            code_next = sel_code;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered state: a capture sets its bit even when the same bit is being cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_code <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      req_q    <= '0;
    end else begin
      state    <= state_next;
      out_code <= code_next;
      pending  <= pending_kept | capture;
      overflow <= |(capture & pending_kept);
      req_q    <= req_in;
    end
  end

  assign out_valid = (state == PRESENT);

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Self-checking bench for irq_encoder_8to3: an edge-capture and a
// level-capture instance share stimulus and are compared every cycle with a
// behavioural model of the request set and presentation rules.
module tb_irq_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic       out_ready;

  logic [2:0] code_e, code_l;
  logic       valid_e, valid_l;
  logic [7:0] pend_e, pend_l;
  logic       ovf_e, ovf_l;

  int total;
  int bad;

  // model state, index 0 = edge instance, index 1 = level instance
  logic [7:0] m_pend [0:1];
  logic [7:0] m_prev [0:1];
  logic       m_valid[0:1];
  int         m_code [0:1];
  logic       m_ovf  [0:1];
  int         m_rr   [0:1];

  irq_encoder_8to3 #(.EDGE(1)) dut_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .out_code  (code_e),
    .out_valid (valid_e),
    .out_ready (out_ready),
    .pending   (pend_e),
    .overflow  (ovf_e)
  );

  irq_encoder_8to3 #(.EDGE(0)) dut_level (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .out_code  (code_l),
    .out_valid (valid_l),
    .out_ready (out_ready),
    .pending   (pend_l),
    .overflow  (ovf_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int v = 0; v < 2; v++) begin
      m_pend[v]  = '0;
      m_prev[v]  = '0;
      m_valid[v] = 1'b0;
      m_code[v]  = 0;
      m_ovf[v]   = 1'b0;
      m_rr[v]    = 7;
    end
  endfunction

  // One clock edge: accept the presented code, pick the next request from what
  // is left (captures of this edge excluded), then add this edge's captures.
  function automatic void modelStep(input logic [7:0] req, input logic rdy);
    for (int v = 0; v < 2; v++) begin
      logic [7:0] cap;
      int taken;
      int start;
      int found;
      for (int i = 0; i < 8; i++)
        cap[i] = (v == 0) ? (req[i] & ~m_prev[v][i]) : req[i];
      taken = -1;
      if (m_valid[v] && rdy) begin
        taken = m_code[v];
        m_pend[v][taken] = 1'b0;
        m_rr[v] = taken;
      end
      m_ovf[v] = |(cap & m_pend[v]);
      if (!m_valid[v] || taken >= 0) begin
`ifdef IRQ_ENC_ROUND_ROBIN_EN
        start = (m_rr[v] + 1) % 8;
`else
        start = 0;
`endif
        found = -1;
        for (int k = 0; k < 8; k++)
          if (found < 0 && m_pend[v][(start + k) % 8]) found = (start + k) % 8;
        if (found >= 0) begin
          m_valid[v] = 1'b1;
          m_code[v]  = found;
        end else begin
          m_valid[v] = 1'b0;
        end
      end
      m_pend[v] = m_pend[v] | cap;
      m_prev[v] = req;
    end
  endfunction

  task automatic compareModel();
    checkOutput("edge_valid", {7'b0, valid_e}, {7'b0, m_valid[0]});
    checkOutput("edge_pending", pend_e, m_pend[0]);
    checkOutput("edge_overflow", {7'b0, ovf_e}, {7'b0, m_ovf[0]});
    if (m_valid[0]) checkOutput("edge_code", {5'b0, code_e}, 8'(m_code[0]));
    checkOutput("level_valid", {7'b0, valid_l}, {7'b0, m_valid[1]});
    checkOutput("level_pending", pend_l, m_pend[1]);
    checkOutput("level_overflow", {7'b0, ovf_l}, {7'b0, m_ovf[1]});
    if (m_valid[1]) checkOutput("level_code", {5'b0, code_l}, 8'(m_code[1]));
  endtask

  task automatic applyStimulus(input logic [7:0] req, input logic rdy);
    req_in    = req;
    out_ready = rdy;
    @(posedge clk);
    modelStep(req, rdy);
    #1;
    compareModel();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid_e"}, {7'b0, valid_e}, 8'h00);
    checkOutput({tag, "_pend_e"}, pend_e, 8'h00);
    checkOutput({tag, "_ovf_e"}, {7'b0, ovf_e}, 8'h00);
    checkOutput({tag, "_code_e"}, {5'b0, code_e}, 8'h00);
    checkOutput({tag, "_valid_l"}, {7'b0, valid_l}, 8'h00);
    checkOutput({tag, "_pend_l"}, pend_l, 8'h00);
  endtask

  // Asserts reset between clock edges and checks the outputs clear without a clock.
  task automatic doReset(input string tag);
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkResetState(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    logic       rdy;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_in    = '0;
    out_ready = 1'b0;
    modelReset();
    #12;
    checkResetState("reset");
    rst_n = 1'b1;

    // single request, two-edge latency
    applyStimulus(8'h04, 1'b1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("lat_code", {5'b0, code_e}, 8'd2);
    checkOutput("lat_valid", {7'b0, valid_e}, 8'd1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1);

    // fixed priority pair
    applyStimulus(8'h81, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(8'h00, 1'b1);

    // backpressure hold then drain
    applyStimulus(8'h12, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1);

    // overflow on a re-captured pending bit
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h08, 1'b0);
    checkOutput("ovf_pulse", {7'b0, ovf_e}, 8'd1);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1);

    // re-capture on the transfer edge: no overflow, second transfer
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h08, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(8'h00, 1'b1);

    // all requests held high
    for (int i = 0; i < 10; i++) applyStimulus(8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(8'h00, 1'b1);

    // reset while presenting
    applyStimulus(8'h0F, 1'b0);
    applyStimulus(8'h00, 1'b0);
    doReset("midreset");
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1);

    // randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 149) doReset("rndreset");
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      else r = 8'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(r, rdy);
    end
    for (int i = 0; i < 12; i++) applyStimulus(8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_encoder_8to3.md
IRQ_ENCODER_8TO3 -- requirements
Module: irq_encoder_8to3

Interface
REQ-001 Parameter EDGE, default 1: 1 = capture rising edges of req_in, 0 = capture levels.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_in  input  8  request lines from the sources; bit i maps to code i.
REQ-005 out_code  output  3  encoded index of the presented request, registered.
REQ-006 out_valid  output  1  out_code is valid, registered.
REQ-007 out_ready  input  1  downstream accepts out_code when out_valid=1 and out_ready=1.
REQ-008 pending  output  8  captured and not yet accepted requests, registered.
REQ-009 overflow  output  1  one-cycle pulse: a capture hit a bit already pending.

Function
REQ-010 Capture SHALL be: EDGE=1 -> req_in[i] & ~req_q[i]; EDGE=0 -> req_in[i]; req_q is req_in registered every cycle.
REQ-011 A capture on edge k SHALL set pending[i] after edge k, visible as pending[i]=1 in the following cycle.
REQ-012 Handshake: the transfer occurs on any edge with out_valid=1 and out_ready=1, and SHALL clear pending[out_code] at that edge.
REQ-013 Simultaneous capture and transfer of the same bit: the set SHALL win, pending[i] stays 1, overflow stays 0.
REQ-014 overflow SHALL pulse for one cycle when a capture hits pending[i]=1 not being cleared that edge; the request is merged.
REQ-015 Two-state FSM: IDLE (out_valid=0) and PRESENT (out_valid=1).
REQ-016 IDLE -> PRESENT when pending (excluding a bit being cleared) is nonzero; out_code is loaded with the selected index on that edge.
REQ-017 PRESENT with out_ready=0 SHALL hold out_code and out_valid stable.
REQ-018 PRESENT with transfer: if other bits remain pending, reload out_code with the next selection and stay in PRESENT (back-to-back, one transfer per cycle); otherwise go to IDLE.
REQ-019 Selection SHALL use pending after clearing the transferred bit but before that edge's new captures.
REQ-020 Latency SHALL be two edges: from the edge that samples a new request to out_valid=1.
REQ-021 Fixed priority (default) SHALL select the lowest set index, matching encoder_8to3 semantics for one-hot input.

Reset
REQ-022 rst_n=0 SHALL immediately force out_code=0, out_valid=0, pending=0, overflow=0, req_q=0, FSM=IDLE, rr_ptr=7.
REQ-023 Reset mid-transfer SHALL discard all pending requests; no out_valid pulse after release until a new capture.
REQ-024 req_in high at reset release with EDGE=1 SHALL count as a rising edge, because req_q resets to 0.

Configuration
REQ-025 Macro IRQ_ENC_ROUND_ROBIN_EN defined: selection SHALL search upward from rr_ptr+1, wrapping 7->0. rr_ptr SHALL update to the transferred index on each transfer.
REQ-026 Macro IRQ_ENC_ROUND_ROBIN_EN undefined: fixed lowest-index priority per REQ-021. rr_ptr SHALL be absent.

Structure
REQ-027 A shared package SHALL hold the constants N_REQ=8 and CODE_W=3, plus the FSM state typedef {IDLE, PRESENT}.
REQ-028 Selection logic SHALL be one combinational sub-module, irq_select_8, with inputs pending[7:0] and start[2:0] and outputs code[2:0] and any. Fixed priority SHALL use start=0.

Verification
REQ-029 EDGE=1, out_ready=1: pulse req_in=8'b0000_0100 for one cycle -> out_valid=1 with out_code=3'd2 exactly two edges later, for one cycle; pending returns to 0.
REQ-030 Fixed priority: capture 8'b1000_0001 in one cycle with out_ready=1 -> codes 0 then 7 on consecutive cycles, then out_valid=0.
REQ-031 Backpressure: out_ready=0 with pending 8'b0001_0010 -> out_code=1 held stable for 5 cycles. Then out_ready=1 -> 1 then 4 transfer.
REQ-032 Overflow: with bit 3 pending and out_ready=0, a second rising edge on req_in[3] -> overflow=1 for one cycle and exactly one code-3 transfer. Also: a re-capture on the transfer edge -> no overflow and a second code-3 transfer.
REQ-033 IRQ_ENC_ROUND_ROBIN_EN: hold req_in=8'hFF with EDGE=0 and out_ready=1 -> codes 0,1,2,...,7,0 in sequence.
REQ-034 Reset: assert rst_n=0 while out_valid=1 and pending=8'h0F -> all outputs 0 asynchronously. With req_in=0 after release, out_valid stays 0.
